alu_issue_sched: RTL



---
 rtl/rs_pkg.sv | 22 ++
 rtl/oldest_ready_pick.sv | 55 +++++
 rtl/alu_issue_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared constants and entry-status record for the ALU reservation station.
package rs_pkg;
   localparam int ENTRIES = 8;
   localparam int AGE_W   = 6;
   localparam int TAG_W   = 6;
   localparam int NWK     = 3;
   localparam int IDX_W   = $clog2(ENTRIES);
   localparam int OCC_W   = IDX_W + 1;

   typedef struct packed {
      logic             busy;
      logic             issued;
      logic             fu;
      logic [TAG_W-1:0] s1_tag;
      logic             s1_rdy;
      logic [TAG_W-1:0] s2_tag;
      logic             s2_rdy;
      logic [AGE_W-1:0] age;
      logic [TAG_W-1:0] dst_tag;
      logic             dst_val;
   } rs_status_t;
endpackage

// File: rtl/oldest_ready_pick.sv
// Oldest-ready selector: binary tree of unsigned age compares; equal ages resolve
// toward the lower entry index.
module oldest_ready_pick
   import rs_pkg::*;
(
   input  logic [ENTRIES-1:0]       cand,
   input  logic [ENTRIES*AGE_W-1:0] ages,
   output logic                     any,
   output logic [IDX_W-1:0]         idx
);
   localparam int NODES = 2 * ENTRIES - 1;

   typedef struct packed {
      logic             any;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // Heap layout: leaves at ENTRIES-1+i, node n has children 2n+1 (lower entries) and 2n+2.
   function automatic pick_t tree_pick(input logic [ENTRIES-1:0]       c,
                                       input logic [ENTRIES*AGE_W-1:0] a);
      logic [NODES-1:0] v;
      logic [AGE_W-1:0] na [NODES];
      logic [IDX_W-1:0] ni [NODES];
      pick_t            res;
      v = '0;
      for (int n = 0; n < NODES; n++) begin
         na[n] = '0;
         ni[n] = '0;
      end
      for (int i = 0; i < ENTRIES; i++) begin
         v[ENTRIES-1+i]  = c[i];
         na[ENTRIES-1+i] = a[i*AGE_W +: AGE_W];
         ni[ENTRIES-1+i] = IDX_W'(i);
      end
      for (int n = ENTRIES - 2; n >= 0; n--) begin
         if (v[2*n+2] && (!v[2*n+1] || (na[2*n+2] < na[2*n+1]))) begin
            na[n] = na[2*n+2];
            ni[n] = ni[2*n+2];
         end else begin
            na[n] = na[2*n+1];
            ni[n] = ni[2*n+1];
         end
         v[n] = v[2*n+1] | v[2*n+2];
      end
      res.any = v[0];
      res.idx = ni[0];
      return res;
   endfunction

   pick_t result;

   assign result = tree_pick(cand, ages);
   assign any    = result.any;
   assign idx    = result.idx;
endmodule

// File: rtl/alu_issue_sched.sv
// ALU reservation-station scheduler: entry status, lowest-free allocation, tag wakeup
// and one registered oldest-ready issue port per ALU.
module alu_issue_sched
   import rs_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 disp_valid,
   output logic                 disp_ready,
   input  logic [AGE_W-1:0]     disp_age,
   input  logic                 disp_fu,
   input  logic [TAG_W-1:0]     disp_s1_tag,
   input  logic [TAG_W-1:0]     disp_s2_tag,
   input  logic                 disp_s1_rdy,
   input  logic                 disp_s2_rdy,
   input  logic [TAG_W-1:0]     disp_dst_tag,
   input  logic                 disp_dst_val,
   output logic [IDX_W-1:0]     alloc_idx,
   input  logic [NWK-1:0]       wk_valid,
   input  logic [NWK*TAG_W-1:0] wk_tag,
   output logic                 iss_valid0,
   input  logic                 iss_ready0,
   output logic [IDX_W-1:0]     iss_idx0,
   output logic [TAG_W-1:0]     iss_dst_tag0,
   output logic                 iss_dst_val0,
   output logic                 iss_valid1,
   input  logic                 iss_ready1,
   output logic [IDX_W-1:0]     iss_idx1,
   output logic [TAG_W-1:0]     iss_dst_tag1,
   output logic                 iss_dst_val1,
   output logic [OCC_W-1:0]     occupancy
);
   rs_status_t [ENTRIES-1:0] rs, rs_nxt;
   logic [ENTRIES-1:0]       cand0, cand1;
   logic [ENTRIES*AGE_W-1:0] ages;
   logic                     any0, any1;
   logic [IDX_W-1:0]         pick0, pick1;
   logic                     fire_disp, fire0, fire1, load0, load1;

   function automatic logic wk_hit(input logic [TAG_W-1:0]     tag,
                                   input logic [NWK-1:0]       v,
                                   input logic [NWK*TAG_W-1:0] t);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NWK; i++)
         if (v[i] && (t[i*TAG_W +: TAG_W] == tag)) hit = 1'b1;
      return hit;
   endfunction

   assign disp_ready = (occupancy < OCC_W'(ENTRIES));
   assign fire_disp  = disp_valid && disp_ready;
   assign fire0      = iss_valid0 && iss_ready0;
   assign fire1      = iss_valid1 && iss_ready1;
   assign load0      = !iss_valid0 || iss_ready0;
   assign load1      = !iss_valid1 || iss_ready1;

   always_comb begin
      alloc_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (!rs[i].busy) alloc_idx = IDX_W'(i);
   end

   always_comb begin
      cand0 = '0;
      cand1 = '0;
      ages  = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         ages[i*AGE_W +: AGE_W] = rs[i].age;
         if (rs[i].busy && rs[i].s1_rdy && rs[i].s2_rdy && !rs[i].issued) begin
            cand0[i] = !rs[i].fu;
            cand1[i] = rs[i].fu;
         end
      end
   end

   oldest_ready_pick u_pick0 (.cand(cand0), .ages(ages), .any(any0), .idx(pick0));
   oldest_ready_pick u_pick1 (.cand(cand1), .ages(ages), .any(any1), .idx(pick1));

   // Allocation, picks and frees all index distinct entries, so their order here is free.
   always_comb begin
      rs_nxt = rs;
      for (int i = 0; i < ENTRIES; i++) begin
         if (rs[i].busy) begin
            if (wk_hit(rs[i].s1_tag, wk_valid, wk_tag)) rs_nxt[i].s1_rdy = 1'b1;
            if (wk_hit(rs[i].s2_tag, wk_valid, wk_tag)) rs_nxt[i].s2_rdy = 1'b1;
         end
      end
      if (fire0) rs_nxt[iss_idx0] = '0;
      if (fire1) rs_nxt[iss_idx1] = '0;
      if (load0 && any0) rs_nxt[pick0].issued = 1'b1;
      if (load1 && any1) rs_nxt[pick1].issued = 1'b1;
      if (fire_disp) begin
         rs_nxt[alloc_idx].busy    = 1'b1;
         rs_nxt[alloc_idx].issued  = 1'b0;
         rs_nxt[alloc_idx].fu      = disp_fu;
         rs_nxt[alloc_idx].s1_tag  = disp_s1_tag;
         rs_nxt[alloc_idx].s1_rdy  = disp_s1_rdy || wk_hit(disp_s1_tag, wk_valid, wk_tag);
         rs_nxt[alloc_idx].s2_tag  = disp_s2_tag;
         rs_nxt[alloc_idx].s2_rdy  = disp_s2_rdy || wk_hit(disp_s2_tag, wk_valid, wk_tag);
         rs_nxt[alloc_idx].age     = disp_age;
         rs_nxt[alloc_idx].dst_tag = disp_dst_tag;
         rs_nxt[alloc_idx].dst_val = disp_dst_val;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rs           <= '0;
         occupancy    <= '0;
         iss_valid0   <= 1'b0;
         iss_idx0     <= '0;
         iss_dst_tag0 <= '0;
         iss_dst_val0 <= 1'b0;
         iss_valid1   <= 1'b0;
         iss_idx1     <= '0;
         iss_dst_tag1 <= '0;
         iss_dst_val1 <= 1'b0;
      end else begin
         rs        <= rs_nxt;
         occupancy <= occupancy + OCC_W'(fire_disp) - OCC_W'(fire0) - OCC_W'(fire1);
         if (load0) begin
            iss_valid0 <= any0;
            if (any0) begin
               iss_idx0     <= pick0;
               iss_dst_tag0 <= rs[pick0].dst_tag;
               iss_dst_val0 <= rs[pick0].dst_val;
            end
         end
         if (load1) begin
            iss_valid1 <= any1;
            if (any1) begin
               iss_idx1     <= pick1;
               iss_dst_tag1 <= rs[pick1].dst_tag;
               iss_dst_val1 <= rs[pick1].dst_val;
            end
         end
      end
   end
endmodule
